// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit for hi/lo writes.
// Accepts one mult/multu/div/divu from IDLE and runs 32 shift-add or
// restoring shift-subtract iterations in CALC. Results are presented
// for a single DONE cycle with the hilo_we strobe.
module mdu_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        stallreq,
   output logic        busy,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic        is_div_q;   // 1: divide, 0: multiply
   logic        neg_q;      // negate product / quotient
   logic        rsign_q;    // remainder takes dividend sign
   logic        dz_q;       // divide by zero
   logic [31:0] raw_q;      // unmodified src1, returned in hi on divide by zero
   logic [31:0] b_q;        // multiplicand magnitude (mul) or divisor magnitude (div)
   logic [63:0] work;       // {hi_acc, lo_acc} for mul, {rem, quo} for div

   // operand decode at acceptance; op[0]=0 selects the signed variants
   logic        sign1, sign2, accept;
   logic [31:0] mag1, mag2;
   assign sign1  = ~op[0] & src1[31];
   assign sign2  = ~op[0] & src2[31];
   assign mag1   = sign1 ? (~src1 + 32'd1) : src1;
   assign mag2   = sign2 ? (~src2 + 32'd1) : src2;
   assign accept = (state == IDLE) & start & ~flush;

   // one iteration of each algorithm
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [32:0] div_up;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] div_nxt;
   assign mul_sum = {1'b0, work[63:32]} + {1'b0, (work[0] ? b_q : 32'd0)};
   assign mul_nxt = {mul_sum, work[31:1]};
   assign div_up  = work[63:31];
   assign div_ge  = div_up >= {1'b0, b_q};
   // the true difference is below 2^32 whenever div_ge holds
   assign div_sub = div_up[31:0] - b_q;
   assign div_nxt = div_ge ? {div_sub, work[30:0], 1'b1} : {work[62:0], 1'b0};

   // final sign fix-up
   logic [63:0] mul_res;
   logic [31:0] quo, rem, div_lo, div_hi;
   assign mul_res = neg_q ? (~work + 64'd1) : work;
   assign quo     = work[31:0];
   assign rem     = work[63:32];
   assign div_lo  = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
   assign div_hi  = dz_q ? raw_q : (rsign_q ? (~rem + 32'd1) : rem);

   assign busy = (state != IDLE);

   // state, counter and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
         raw_q    <= 32'd0;
         b_q      <= 32'd0;
         work     <= 64'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt      <= 6'd0;
            is_div_q <= op[1];
            neg_q    <= sign1 ^ sign2;
            rsign_q  <= sign1;
            dz_q     <= op[1] & (src2 == 32'd0);
            raw_q    <= src1;
            b_q      <= op[1] ? mag2 : mag1;
            work     <= {32'd0, (op[1] ? mag1 : mag2)};
         end else if (state == CALC) begin
            cnt  <= cnt + 6'd1;
            work <= is_div_q ? div_nxt : mul_nxt;
         end
      end
   end

   // next state and outputs; flush always wins back to IDLE
   always_comb begin
      state_nxt = state;
      stallreq  = 1'b0;
      hilo_we   = 1'b0;
      hi_wdata  = 32'd0;
      lo_wdata  = 32'd0;
      case (state)
         IDLE: begin
            stallreq = start & ~flush;
            if (accept) state_nxt = CALC;
         end
         CALC: begin
            stallreq = ~flush;
            if (cnt == 6'd31) state_nxt = DONE;
         end
         DONE: begin
            hilo_we   = ~flush;
            hi_wdata  = is_div_q ? div_hi : mul_res[63:32];
            lo_wdata  = is_div_q ? div_lo : mul_res[31:0];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an
// arithmetic reference model.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] src1 = 32'd0, src2 = 32'd0;
   logic        flush = 1'b0;
   logic        stallreq, busy, hilo_we;
   logic [31:0] hi_wdata, lo_wdata;

   int checks = 0;
   int errors = 0;

   mdu_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op),
      .src1(src1), .src2(src2), .flush(flush),
      .stallreq(stallreq), .busy(busy), .hilo_we(hilo_we),
      .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   always #5 clk = ~clk;

   // reference: {hi, lo} from plain integer arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, q, r;
      logic [63:0] p;
      ia = a; ib = b; sa = ia; sb = ib;
      case (o)
         2'd0: begin p = sa * sb; return p; end
         2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drives an op in IDLE (cycle 0) and returns during cycle stop_at
   task automatic begin_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int stop_at);
      start = 1'b1; op = o; src1 = a; src2 = b;
      #1 chk("accept_stall", stallreq, 1);
      step();
      start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
      for (int c = 1; c < stop_at; c++) begin
         chk($sformatf("calc_stall_c%0d", c), stallreq, 1);
         chk($sformatf("calc_busy_c%0d", c), busy, 1);
         chk($sformatf("calc_we_c%0d", c), hilo_we, 0);
         step();
      end
   endtask

   task automatic check_done(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      e = model(o, a, b);
      chk({tag, "_we"}, hilo_we, 1);
      chk({tag, "_stall"}, stallreq, 0);
      chk({tag, "_hi"}, hi_wdata, e[63:32]);
      chk({tag, "_lo"}, lo_wdata, e[31:0]);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      begin_op(o, a, b, 33);
      check_done(tag, o, a, b);
      step();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] a, b;

      // reset state
      #2;
      chk("rst_stall", stallreq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", hilo_we, 0);
      chk("rst_hi", hi_wdata, 0);
      chk("rst_lo", lo_wdata, 0);
      step();
      resetn = 1'b1;

      // directed vectors
      run_op("multu_ffff_x2", 2'd1, 32'hFFFF_FFFF, 32'd2);
      chk("multu_ref_hi_lo", model(2'd1, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
      run_op("mult_m3_x5", 2'd0, 32'hFFFF_FFFD, 32'd5);
      run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
      run_op("divu_7_0", 2'd3, 32'd7, 32'd0);
      run_op("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_m7_0", 2'd2, 32'hFFFF_FFF9, 32'd0);
      run_op("mult_min_min", 2'd0, 32'h8000_0000, 32'h8000_0000);

      // start together with flush in IDLE is refused
      start = 1'b1; flush = 1'b1; op = 2'd1; src1 = 32'd3; src2 = 32'd4;
      #1 chk("flush_idle_stall", stallreq, 0);
      step();
      start = 1'b0; flush = 1'b0;
      chk("flush_idle_busy", busy, 0);

      // flush in CALC cycle 10
      begin_op(2'd1, 32'd1234, 32'd5678, 10);
      flush = 1'b1;
      #1 chk("flush_calc_stall", stallreq, 0);
      step();
      flush = 1'b0;
      chk("flush_calc_busy", busy, 0);
      chk("flush_calc_stall_after", stallreq, 0);
      for (int c = 0; c < 30; c++) begin
         chk("flush_calc_no_we", hilo_we, 0);
         step();
      end
      run_op("divu_100_7", 2'd3, 32'd100, 32'd7);

      // flush in DONE suppresses the write strobe
      begin_op(2'd0, 32'd9, 32'd9, 33);
      flush = 1'b1;
      #1 chk("flush_done_we", hilo_we, 0);
      step();
      flush = 1'b0;
      chk("flush_done_busy", busy, 0);

      // reset pulsed in CALC cycle 20
      begin_op(2'd2, 32'd1000, 32'd3, 20);
      resetn = 1'b0;
      #1;
      chk("rst_calc_stall", stallreq, 0);
      chk("rst_calc_busy", busy, 0);
      chk("rst_calc_we", hilo_we, 0);
      step();
      resetn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         chk("rst_calc_no_we", hilo_we, 0);
         chk("rst_calc_no_busy", busy, 0);
         step();
      end

      // start held through DONE: second op only accepted after DONE
      begin_op(2'd1, 32'd6, 32'd7, 33);
      start = 1'b1; op = 2'd3; src1 = 32'd50; src2 = 32'd8;
      #1;
      check_done("b2b_first", 2'd1, 32'd6, 32'd7);
      step();
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_stall", stallreq, 1);
      run_op("b2b_second", 2'd3, 32'd50, 32'd8);

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 255);
            2: b = 32'hFFFF_FFFF - $urandom_range(0, 255);
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, o), o, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global time limit
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
